// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: state enum, opcodes
// and the datapath mux select values.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    LBRD,
    LBWR,
    SBWR,
    RTYPEEX,
    RTYPEWR,
    BEQEX,
    JEX,
    ADDIWR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_ONE    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_fetch_seq.sv
// Instruction fetch beat counter with one-hot instruction-register byte enable.
// The beat only advances on accepted beats and wraps after the last one.
module mc_fetch_seq #(
  parameter int INSTR_BYTES = 4,
  parameter int BEAT_W      = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   mem_ready,
  output logic                   last_beat,
  output logic [INSTR_BYTES-1:0] irwrite
);

  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(INSTR_BYTES - 1);

  logic [BEAT_W-1:0] beat;
  logic              accept;

  assign accept    = en && mem_ready;
  assign last_beat = (beat == LAST);
  assign irwrite   = accept ? (INSTR_BYTES'(1) << beat) : '0;

  // Wrapping on the last beat keeps the counter at 0 whenever FETCH is left.
  always_ff @(posedge clk) begin
    if (rst)
      beat <= '0;
    else if (accept)
      beat <= last_beat ? '0 : beat + 1'b1;
  end

endmodule

// File: rtl/mc_controller.sv
// Parametrised multicycle MIPS control FSM with memory-ready stalls.
// Optional BNE support is enabled by defining MC_BNE_EN.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int INSTR_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             op,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   memread,
  output logic                   memwrite,
  output logic                   iord,
  output logic [INSTR_BYTES-1:0] irwrite,
  output logic                   alusrca,
  output logic [1:0]             alusrcb,
  output logic [1:0]             aluop,
  output logic [1:0]             pcsource,
  output logic                   pcwrite,
  output logic                   branch,
  output logic                   pcen,
  output logic                   regwrite,
  output logic                   regdst,
  output logic                   memtoreg,
  output logic                   illegal_op
);

  localparam int BEAT_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

  state_t                 state, state_n;
  logic                   fetch_en;
  logic                   last_beat;
  logic                   taken;
  logic [INSTR_BYTES-1:0] irw_seq;

  assign fetch_en = (state == FETCH);

  mc_fetch_seq #(
    .INSTR_BYTES(INSTR_BYTES),
    .BEAT_W     (BEAT_W)
  ) u_fetch (
    .clk      (clk),
    .rst      (rst),
    .en       (fetch_en),
    .mem_ready(mem_ready),
    .last_beat(last_beat),
    .irwrite  (irw_seq)
  );

`ifdef MC_BNE_EN
  logic bne_q;

  // Remember whether the decoded branch is BNE so BEQEX can invert the test.
  always_ff @(posedge clk) begin
    if (rst)
      bne_q <= 1'b0;
    else if (state == DECODE)
      bne_q <= (op == OP_BNE);
  end

  assign taken = zero ^ bne_q;
`else
  assign taken = zero;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= FETCH;
    else
      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = '0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REGB;
    aluop      = ALU_ADD;
    pcsource   = PC_ALU;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    pcen       = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    illegal_op = 1'b0;

    case (state)
      FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_ONE;
        if (mem_ready) begin
          irwrite = irw_seq;
          pcwrite = 1'b1;
          if (last_beat)
            state_n = DECODE;
        end
      end
      DECODE: begin
        alusrcb = SRCB_IMMSH2;
        case (op)
          OP_LB, OP_SB, OP_ADDI: state_n = MEMADR;
          OP_RTYPE:              state_n = RTYPEEX;
          OP_BEQ:                state_n = BEQEX;
`ifdef MC_BNE_EN
          OP_BNE:                state_n = BEQEX;
`endif
          OP_J:                  state_n = JEX;
          default: begin
            illegal_op = 1'b1;
            state_n    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        case (op)
          OP_LB:   state_n = LBRD;
          OP_SB:   state_n = SBWR;
          OP_ADDI: state_n = ADDIWR;
          default: state_n = FETCH;
        endcase
      end
      LBRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready)
          state_n = LBWR;
      end
      LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_n  = FETCH;
      end
      SBWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready)
          state_n = FETCH;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALU_FUNCT;
        state_n = RTYPEWR;
      end
      RTYPEWR: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_n  = FETCH;
      end
      ADDIWR: begin
        regwrite = 1'b1;
        state_n  = FETCH;
      end
      BEQEX: begin
        alusrca  = 1'b1;
        aluop    = ALU_SUB;
        branch   = 1'b1;
        pcsource = PC_ALUOUT;
        state_n  = FETCH;
      end
      JEX: begin
        pcwrite  = 1'b1;
        pcsource = PC_JUMP;
        state_n  = FETCH;
      end
      default: state_n = FETCH;
    endcase

    pcen = pcwrite | (branch & taken);

    // Reset silences every output, even mid-instruction.
    if (rst) begin
      memread    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = '0;
      alusrca    = 1'b0;
      alusrcb    = '0;
      aluop      = '0;
      pcsource   = '0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      pcen       = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule
